eaglesong_nonce_search: RTL and testbench

Mining front-end that sits directly upstream and downstream of `eaglesong_digest_top`. It accepts a job containing a 16-byte prefix, a nonce range and a 256-bit target. For each nonce it builds the 32-byte message, starts the digest core and waits for its result. It compares the digest against the target and reports the first winning nonce, or range exhaustion / abort, through a held result handshake.

---
 rtl/eaglesong_nonce_search.sv | 200 ++++++++++++++++++++
 tb/tb_eaglesong_nonce_search.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eaglesong_nonce_search.sv
// eaglesong_nonce_search: mining front-end around eaglesong_digest_top.
// For each nonce in [start, start+count) it builds the 32-byte message
// {nonce (LE, zero-extended to 16 bytes), prefix}, runs one digest and compares
// the digest (byte 0 most significant) against the target. It reports the
// first winner, range exhaustion or abort on a held res_valid/res_ready handshake.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   job_valid/job_ready, job_*        job intake (prefix, nonce start/count, target)
//   abort                             cancel a running search
//   dig_*                             connection to the digest core
//   res_valid/res_ready, res_*        result handshake and payload
//   busy                              search in progress
//   perf_hashes                       completed digest count
//
// Optional build macro: EAGLESONG_NONCE_SEARCH_PERF_EN enables the perf_hashes
// counter; without it perf_hashes is tied to 0.
module eaglesong_nonce_search #(
  parameter int unsigned NONCE_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [127:0]       job_prefix,
  input  logic [NONCE_W-1:0] job_nonce_start,
  input  logic [NONCE_W-1:0] job_nonce_count,
  input  logic [255:0]       job_target,
  input  logic               abort,
  output logic [255:0]       dig_input_val,
  output logic [6:0]         dig_input_length_bytes,
  output logic               dig_start_eval,
  input  logic [255:0]       dig_output_val,
  input  logic               dig_eval_output_ready,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_found,
  output logic               res_aborted,
  output logic [NONCE_W-1:0] res_nonce,
  output logic [255:0]       res_hash,
  output logic               busy,
  output logic [31:0]        perf_hashes
);

  localparam int unsigned NONCE_FIELD_W = 128;
  localparam int unsigned HASH_W        = 256;
  localparam int unsigned HASH_BYTES    = HASH_W / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT_CLR, S_WAIT, S_CHECK, S_RESULT
  } state_t;

  state_t               state, state_n;
  logic [NONCE_W-1:0]   nonce, remaining, nonce_next_c;
  logic [HASH_W-1:0]    target, hash_raw, hash_num_c;
  logic                 hit_c, accept_c, advance_c, capture_c, load_res_c;
  logic                 found_n_c, aborted_n_c;

  assign dig_input_length_bytes = 7'd32;
  assign nonce_next_c           = nonce + NONCE_W'(1);

  // Digest byte 0 is the most significant byte of the numeric hash.
  always_comb begin
    hash_num_c = '0;
    for (int i = 0; i < int'(HASH_BYTES); i++)
      hash_num_c[8*(int'(HASH_BYTES)-1-i) +: 8] = hash_raw[8*i +: 8];
  end

  assign hit_c = (hash_num_c <= target);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state and datapath control.
  always_comb begin
    state_n     = state;
    accept_c    = 1'b0;
    advance_c   = 1'b0;
    capture_c   = 1'b0;
    load_res_c  = 1'b0;
    found_n_c   = 1'b0;
    aborted_n_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (job_valid) begin
          accept_c = 1'b1;
          if (job_nonce_count == '0) begin
            state_n    = S_RESULT;
            load_res_c = 1'b1;
          end else begin
            state_n = S_START;
          end
        end
      end
      S_START, S_WAIT_CLR: begin
        // The digest clears its ready one edge after start, so it is not looked at here.
        if (abort) begin
          state_n     = S_RESULT;
          load_res_c  = 1'b1;
          aborted_n_c = 1'b1;
        end else begin
          state_n = (state == S_START) ? S_WAIT_CLR : S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_n     = S_RESULT;
          load_res_c  = 1'b1;
          aborted_n_c = 1'b1;
        end else if (dig_eval_output_ready) begin
          state_n   = S_CHECK;
          capture_c = 1'b1;
        end
      end
      S_CHECK: begin
        // A hit in the same cycle as abort is still reported as a hit.
        if (hit_c) begin
          state_n    = S_RESULT;
          load_res_c = 1'b1;
          found_n_c  = 1'b1;
        end else if (abort) begin
          state_n     = S_RESULT;
          load_res_c  = 1'b1;
          aborted_n_c = 1'b1;
        end else if (remaining == NONCE_W'(1)) begin
          state_n    = S_RESULT;
          load_res_c = 1'b1;
        end else begin
          state_n   = S_START;
          advance_c = 1'b1;
        end
      end
      S_RESULT: begin
        if (res_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Registered outputs and search datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      job_ready      <= 1'b1;
      busy           <= 1'b0;
      dig_start_eval <= 1'b0;
      res_valid      <= 1'b0;
      res_found      <= 1'b0;
      res_aborted    <= 1'b0;
      res_nonce      <= '0;
      res_hash       <= '0;
      dig_input_val  <= '0;
      nonce          <= '0;
      remaining      <= '0;
      target         <= '0;
      hash_raw       <= '0;
    end else begin
      job_ready      <= (state_n == S_IDLE);
      busy           <= (state_n inside {S_START, S_WAIT_CLR, S_WAIT, S_CHECK});
      dig_start_eval <= (state_n == S_START);
      res_valid      <= (state_n == S_RESULT);
      if (accept_c) begin
        nonce         <= job_nonce_start;
        remaining     <= job_nonce_count;
        target        <= job_target;
        hash_raw      <= '0;
        dig_input_val <= {NONCE_FIELD_W'(job_nonce_start), job_prefix};
      end
      if (capture_c) hash_raw <= dig_output_val;
      if (advance_c) begin
        nonce                <= nonce_next_c;
        remaining            <= remaining - NONCE_W'(1);
        dig_input_val[255:128] <= NONCE_FIELD_W'(nonce_next_c);
      end
      if (load_res_c) begin
        res_found   <= found_n_c;
        res_aborted <= aborted_n_c;
        res_nonce   <= accept_c ? job_nonce_start : nonce;
        res_hash    <= accept_c ? '0 : hash_raw;
      end
    end
  end

`ifdef EAGLESONG_NONCE_SEARCH_PERF_EN
  logic [31:0] perf_q;

  // One count per CHECK cycle, i.e. per completed digest.
  always_ff @(posedge clk) begin
    if (rst)                  perf_q <= '0;
    else if (state == S_CHECK) perf_q <= perf_q + 32'd1;
  end

  assign perf_hashes = perf_q;
`else
  assign perf_hashes = '0;
`endif

endmodule

// File: tb/tb_eaglesong_nonce_search.sv
// Directed bench for eaglesong_nonce_search with a behavioural digest stand-in.
module tb_eaglesong_nonce_search;

  localparam int unsigned NW  = 64;
  localparam int unsigned LAT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          job_valid, job_ready;
  logic [127:0]  job_prefix;
  logic [NW-1:0] job_nonce_start, job_nonce_count;
  logic [255:0]  job_target;
  logic          abort;
  logic [255:0]  dig_input_val;
  logic [6:0]    dig_input_length_bytes;
  logic          dig_start_eval;
  logic [255:0]  dig_output_val = {8{32'hDEADBEEF}};
  logic          dig_eval_output_ready = 1'b1;  // stale high, as from an unreset core
  logic          res_valid, res_ready, res_found, res_aborted;
  logic [NW-1:0] res_nonce;
  logic [255:0]  res_hash;
  logic          busy;
  logic [31:0]   perf_hashes;

  int total = 0;
  int bad   = 0;
  int n_starts = 0;
  int m_cnt = 0;
  logic [127:0] start_log[$];

  eaglesong_nonce_search #(.NONCE_W(NW)) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready), .job_prefix(job_prefix),
    .job_nonce_start(job_nonce_start), .job_nonce_count(job_nonce_count),
    .job_target(job_target), .abort(abort),
    .dig_input_val(dig_input_val), .dig_input_length_bytes(dig_input_length_bytes),
    .dig_start_eval(dig_start_eval), .dig_output_val(dig_output_val),
    .dig_eval_output_ready(dig_eval_output_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_found(res_found),
    .res_aborted(res_aborted), .res_nonce(res_nonce), .res_hash(res_hash),
    .busy(busy), .perf_hashes(perf_hashes)
  );

  always #5 clk = ~clk;

  // Stand-in digest: output byte 0 = nonce byte 0, byte 1 = prefix byte 0 ^ 5A, rest AA.
  function automatic logic [255:0] dig_f(input logic [255:0] msg);
    return {{30{8'hAA}}, msg[7:0] ^ 8'h5A, msg[135:128]};
  endfunction

  function automatic logic [255:0] mk_msg(input logic [NW-1:0] n, input logic [127:0] p);
    return {64'h0, n, p};
  endfunction

  // Digest timing: ready drops one edge after start, result LAT edges after start.
  always @(posedge clk) begin
    if (dig_start_eval) begin
      n_starts = n_starts + 1;
      start_log.push_back(dig_input_val[255:128]);
      m_cnt = 1;
    end else if (m_cnt != 0) begin
      if (m_cnt == 1) dig_eval_output_ready <= 1'b0;
      if (m_cnt == int'(LAT)) begin
        dig_output_val        <= dig_f(dig_input_val);
        dig_eval_output_ready <= 1'b1;
        m_cnt = 0;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".job_ready"},   256'(job_ready),              256'(1'b1));
    chk({tag, ".start_eval"},  256'(dig_start_eval),         256'(1'b0));
    chk({tag, ".res_valid"},   256'(res_valid),              256'(1'b0));
    chk({tag, ".res_found"},   256'(res_found),              256'(1'b0));
    chk({tag, ".res_aborted"}, 256'(res_aborted),            256'(1'b0));
    chk({tag, ".busy"},        256'(busy),                   256'(1'b0));
    chk({tag, ".res_nonce"},   256'(res_nonce),              256'(0));
    chk({tag, ".res_hash"},    res_hash,                     256'(0));
    chk({tag, ".perf"},        256'(perf_hashes),            256'(0));
    chk({tag, ".dig_in"},      dig_input_val,                256'(0));
    chk({tag, ".len"},         256'(dig_input_length_bytes), 256'(32));
  endtask

  typedef struct {
    logic [127:0]  prefix;
    logic [NW-1:0] start;
    logic [NW-1:0] count;
    logic [255:0]  target;
    logic          exp_found;
    logic [NW-1:0] exp_nonce;
    int            exp_hashes;
  } vec_t;

  task automatic offer(input vec_t v);
    @(negedge clk);
    job_prefix      = v.prefix;
    job_nonce_start = v.start;
    job_nonce_count = v.count;
    job_target      = v.target;
    job_valid       = 1'b1;
    @(negedge clk);
    job_valid       = 1'b0;
  endtask

  task automatic wait_res(output bit got, output int waited);
    got = 1'b0;
    waited = 0;
    for (int i = 0; i < 500; i++) begin
      if (res_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int s0;
    logic [31:0] p0;
    bit got;
    int waited;
    logic [255:0] exp_hash;
    s0 = n_starts;
    p0 = perf_hashes;
    res_ready = 1'b1;
    chk({tag, ".job_ready"}, 256'(job_ready), 256'(1'b1));
    offer(v);
    wait_res(got, waited);
    chk({tag, ".res_seen"}, 256'(got), 256'(1'b1));
    exp_hash = (v.count == '0) ? 256'(0) : dig_f(mk_msg(v.exp_nonce, v.prefix));
    if (got) begin
      chk({tag, ".found"},   256'(res_found),     256'(v.exp_found));
      chk({tag, ".aborted"}, 256'(res_aborted),   256'(1'b0));
      chk({tag, ".nonce"},   256'(res_nonce),     256'(v.exp_nonce));
      chk({tag, ".hash"},    res_hash,            exp_hash);
      chk({tag, ".digests"}, 256'(n_starts - s0), 256'(v.exp_hashes));
`ifdef EAGLESONG_NONCE_SEARCH_PERF_EN
      chk({tag, ".perf"}, 256'(perf_hashes - p0), 256'(v.exp_hashes));
`else
      chk({tag, ".perf"}, 256'(perf_hashes), 256'(0));
`endif
      if (v.count == '0)
        chk({tag, ".latency"}, 256'(waited <= 1), 256'(1'b1));
    end
    @(negedge clk);
    chk({tag, ".released"}, 256'({res_valid, job_ready}), 256'(2'b01));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    vec_t v;
    bit got;
    int waited;
    int s0;
    logic [255:0] tgt_eq;

    tgt_eq = {8'h05, 8'h5A, {30{8'hAA}}};
    vecs[0] = '{128'h0, 64'd5, 64'd10, {256{1'b1}}, 1'b1, 64'd5, 1};
    vecs[1] = '{128'h0, 64'd100, 64'd3, 256'h0, 1'b0, 64'd102, 3};
    vecs[2] = '{128'h0, 64'hFE, 64'd10, {8'h03, {248{1'b1}}}, 1'b1, 64'h100, 3};
    vecs[3] = '{128'h0, 64'd5, 64'd1, tgt_eq, 1'b1, 64'd5, 1};
    vecs[4] = '{128'h0, 64'd6, 64'd1, tgt_eq, 1'b0, 64'd6, 1};
    vecs[5] = '{128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3211, 64'd5, 64'd2,
                {8'h05, 8'h4B, {29{8'hAA}}, 8'hA9}, 1'b0, 64'd6, 2};
    vecs[6] = '{128'hCAFE, 64'd42, 64'd0, 256'h0, 1'b0, 64'd42, 0};

    rst = 1'b1; job_valid = 1'b0; abort = 1'b0; res_ready = 1'b0;
    job_prefix = '0; job_nonce_start = '0; job_nonce_count = '0; job_target = '0;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Nonce wrap at 2^64-1.
    start_log.delete();
    v = '{128'h0, {NW{1'b1}}, 64'd2, 256'h0, 1'b0, 64'd0, 2};
    run_vec(v, "wrap");
    chk("wrap.log_len", 256'(start_log.size()), 256'(2));
    if (start_log.size() == 2) begin
      chk("wrap.msg0", 256'(start_log[0]), 256'(128'hFFFF_FFFF_FFFF_FFFF));
      chk("wrap.msg1", 256'(start_log[1]), 256'(0));
    end

    // Abort in the second WAIT, then hold the result for 20 cycles.
    s0 = n_starts;
    res_ready = 1'b0;
    v = '{128'h0, 64'd20, 64'd5, 256'h0, 1'b0, 64'd21, 2};
    offer(v);
    for (int i = 0; i < 200 && n_starts < s0 + 2; i++) @(negedge clk);
    chk("abort.second_start", 256'(n_starts - s0), 256'(2));
    @(negedge clk);
    chk("abort.busy", 256'(busy), 256'(1'b1));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort.res_valid", 256'(res_valid), 256'(1'b1));
    chk("abort.hash", res_hash, dig_f(mk_msg(64'd20, 128'h0)));
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("hold.c%0d", i),
          256'({res_valid, job_ready, res_aborted, res_found, busy, res_nonce}),
          256'({1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'd21}));
      chk($sformatf("hold.hash%0d", i), res_hash, dig_f(mk_msg(64'd20, 128'h0)));
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("abort.released", 256'({res_valid, job_ready}), 256'(2'b01));
    v = '{128'h77, 64'd7, 64'd1, {256{1'b1}}, 1'b1, 64'd7, 1};
    run_vec(v, "after_abort");

    // Reset while waiting on the digest.
    s0 = n_starts;
    v = '{128'h0, 64'd0, 64'd50, 256'h0, 1'b0, 64'd0, 0};
    offer(v);
    for (int i = 0; i < 50 && n_starts < s0 + 1; i++) @(negedge clk);
    @(negedge clk);
    chk("rst_mid.busy", 256'(busy), 256'(1'b1));
    rst = 1'b1;
    @(negedge clk);
    check_reset("rst_mid");
    rst = 1'b0;
    @(negedge clk);
    v = '{128'h0, 64'd9, 64'd2, 256'h0, 1'b0, 64'd10, 2};
    run_vec(v, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
